// File: rtl/spi_regfile_periph_if.sv
// SPI pin bundle between an external controller and the register-file peripheral.
interface spi_regfile_periph_if;
    logic SCLK;
    logic COPI;
    logic nCS;
    logic CIPO;
    logic cipo_oe;

    modport master (output SCLK, COPI, nCS, input CIPO, cipo_oe);
    modport slave  (input SCLK, COPI, nCS, output CIPO, cipo_oe);
endinterface

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral exposing NUM_REGS x DATA_W registers with readback,
// frame-length checking and address-range error reporting. Runs in clk domain.
module spi_regfile_periph #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ERR_CNT_W   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    spi_regfile_periph_if.slave           bus,
    output logic [NUM_REGS*DATA_W-1:0]    regs_flat,
    output logic                          wr_strobe,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic                          addr_err,
    output logic [ERR_CNT_W-1:0]          frame_err_cnt,
    input  logic                          err_clr
);

    localparam int unsigned FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 2);
    localparam int unsigned LAST      = SYNC_STAGES - 1;

    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_RDATA = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync, ncs_vld;
    logic                   sclk_d, ncs_d, armed;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    logic [2:0]             state, state_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_LEN-1:0]   rx, rx_nxt;
    logic [DATA_W-1:0]      tx, tx_sel;
    logic                   cipo_q, cipo_oe_q;

    logic                   in_frame, bit_c, load_tx_c, tx_shift_c;
    logic                   frame_ok, rx_rw, addr_ok;
    logic [ADDR_W-1:0]      rx_addr;
    logic [DATA_W-1:0]      rx_data;
    logic                   commit_c, set_aerr_c, inc_ferr_c;
    logic [ERR_CNT_W-1:0]   ferr_base, ferr_nxt;

    assign sclk_s    = sclk_sync[LAST];
    assign copi_s    = copi_sync[LAST];
    assign ncs_s     = ncs_sync[LAST];
    assign sclk_rise =  sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s &  sclk_d;
    assign ncs_rise  =  ncs_s  & ~ncs_d;
    assign ncs_fall  = ~ncs_s  &  ncs_d;

    assign in_frame   = (state == S_CMD) || (state == S_WDATA) || (state == S_RDATA);
    assign bit_c      = in_frame && sclk_rise && !ncs_rise;
    assign tx_shift_c = (state == S_RDATA) && sclk_fall && !ncs_rise;
    assign rx_nxt     = {rx[FRAME_LEN-2:0], copi_s};

    assign frame_ok   = (bit_cnt == CNT_FULL);
    assign rx_rw      = rx[FRAME_LEN-1];
    assign rx_addr    = rx[DATA_W +: ADDR_W];
    assign rx_data    = rx[DATA_W-1:0];
    assign addr_ok    = 32'(rx_addr) < NUM_REGS;
    assign commit_c   = (state == S_END) && frame_ok && rx_rw && addr_ok;
    assign set_aerr_c = (state == S_END) && frame_ok && !addr_ok;
    assign inc_ferr_c = (state == S_END) && !frame_ok;

    assign bus.CIPO    = cipo_q;
    assign bus.cipo_oe = cipo_oe_q;

    // Input synchronisers, edge-detect copies, and the arm flag that requires
    // a genuinely observed nCS-high before the first frame after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            ncs_vld   <= '0;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], bus.COPI};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], bus.nCS};
            ncs_vld   <= {ncs_vld[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            ncs_d     <= ncs_s;
            armed     <= armed | (ncs_vld[LAST] & ncs_s);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; nCS rising inside a frame always wins.
    always_comb begin
        state_nxt = state;
        load_tx_c = 1'b0;
        case (state)
            S_IDLE: if (ncs_fall && armed) state_nxt = S_CMD;
            S_CMD: begin
                if (ncs_rise) begin
                    state_nxt = S_END;
                end else if (bit_c && bit_cnt == CNT_ADDR_LAST) begin
                    state_nxt = rx_nxt[ADDR_W] ? S_WDATA : S_RDATA;
                    load_tx_c = !rx_nxt[ADDR_W];
                end
            end
            S_WDATA: if (ncs_rise) state_nxt = S_END;
            S_RDATA: if (ncs_rise) state_nxt = S_END;
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Register selected for readback; out-of-range addresses read as zero.
    always_comb begin
        tx_sel = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rx_nxt[ADDR_W-1:0] == ADDR_W'(i)) tx_sel = regs_flat[i*DATA_W +: DATA_W];
        end
    end

    // Saturating frame-error counter; a new error lands on top of a clear.
    always_comb begin
        ferr_base = err_clr ? '0 : frame_err_cnt;
        ferr_nxt  = ferr_base;
        if (inc_ferr_c && ferr_base != '1) ferr_nxt = ferr_base + ERR_CNT_W'(1);
    end

    // Frame shift/count datapath and CIPO driver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                bit_cnt <= '0;
            end else if (bit_c) begin
                rx <= rx_nxt;
                if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (load_tx_c)       tx <= tx_sel;
            else if (tx_shift_c) tx <= {tx[DATA_W-2:0], 1'b0};
            cipo_oe_q <= (state_nxt == S_RDATA);
            if (state_nxt != S_RDATA) cipo_q <= 1'b0;
            else if (tx_shift_c)      cipo_q <= tx[DATA_W-1];
        end
    end

    // Frame commit and error reporting, evaluated in END.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_flat     <= '0;
            wr_strobe     <= 1'b0;
            wr_addr       <= '0;
            addr_err      <= 1'b0;
            frame_err_cnt <= '0;
        end else begin
            wr_strobe <= commit_c;
            if (commit_c) wr_addr <= rx_addr;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (commit_c && rx_addr == ADDR_W'(i)) regs_flat[i*DATA_W +: DATA_W] <= rx_data;
            end
            addr_err      <= (addr_err & ~err_clr) | set_aerr_c;
            frame_err_cnt <= ferr_nxt;
        end
    end

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Bench for spi_regfile_periph: default instance (8b data, 7b addr, 5 regs)
// and a wide instance (16b data, 4b addr, 12 regs), checked against a
// frame-level reference model.
module tb_spi_regfile_periph;
    localparam int HALF = 80;
    localparam int GAP  = 160;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr_a = 1'b0, err_clr_b = 1'b0;
    logic [39:0]  regs_a;
    logic [191:0] regs_b;
    logic strobe_a, strobe_b, aerr_a, aerr_b;
    logic [6:0] waddr_a;
    logic [3:0] waddr_b;
    logic [3:0] ferr_a, ferr_b;

    int tests = 0, fails = 0;
    int strb_a = 0, strb_b = 0;
    logic [15:0] mdl [2][16];
    int mdl_aerr [2];
    int mdl_ferr [2];

    spi_regfile_periph_if bus_a ();
    spi_regfile_periph_if bus_b ();

    spi_regfile_periph dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .regs_flat(regs_a),
        .wr_strobe(strobe_a), .wr_addr(waddr_a), .addr_err(aerr_a),
        .frame_err_cnt(ferr_a), .err_clr(err_clr_a));

    spi_regfile_periph #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(12), .SYNC_STAGES(2), .ERR_CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .regs_flat(regs_b),
        .wr_strobe(strobe_b), .wr_addr(waddr_b), .addr_err(aerr_b),
        .frame_err_cnt(ferr_b), .err_clr(err_clr_b));

    always #5 clk = ~clk;

    // Count strobe-high cycles per instance.
    always @(posedge clk) begin
        if (strobe_a === 1'b1) strb_a++;
        if (strobe_b === 1'b1) strb_b++;
    end

    function automatic int aw(input int sel); return (sel == 0) ? 7 : 4; endfunction
    function automatic int dw(input int sel); return (sel == 0) ? 8 : 16; endfunction
    function automatic int nr(input int sel); return (sel == 0) ? 5 : 12; endfunction

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_pins(input int sel, input logic s, input logic d, input logic n);
        if (sel == 0) begin bus_a.SCLK = s; bus_a.COPI = d; bus_a.nCS = n; end
        else          begin bus_b.SCLK = s; bus_b.COPI = d; bus_b.nCS = n; end
    endtask

    function automatic logic get_cipo(input int sel); return (sel == 0) ? bus_a.CIPO : bus_b.CIPO; endfunction
    function automatic logic get_oe(input int sel); return (sel == 0) ? bus_a.cipo_oe : bus_b.cipo_oe; endfunction
    function automatic logic [191:0] get_flat(input int sel); return (sel == 0) ? {152'b0, regs_a} : regs_b; endfunction
    function automatic int get_strb(input int sel); return (sel == 0) ? strb_a : strb_b; endfunction
    function automatic int get_aerr(input int sel); return (sel == 0) ? int'(aerr_a) : int'(aerr_b); endfunction
    function automatic int get_ferr(input int sel); return (sel == 0) ? int'(ferr_a) : int'(ferr_b); endfunction
    function automatic int get_waddr(input int sel); return (sel == 0) ? int'(waddr_a) : int'(waddr_b); endfunction

    function automatic logic [191:0] exp_flat(input int sel);
        logic [191:0] e = '0;
        for (int r = 0; r < nr(sel); r++) e = e | (192'(mdl[sel][r]) << (r * dw(sel)));
        return e;
    endfunction

    // One SCLK period: data set on the low phase, CIPO/oe sampled just before the rise.
    task automatic bit_cycle(input int sel, input logic b, output logic c, output logic o);
        set_pins(sel, 1'b0, b, 1'b0);
        #HALF;
        c = get_cipo(sel);
        o = get_oe(sel);
        set_pins(sel, 1'b1, b, 1'b0);
        #HALF;
    endtask

    task automatic frame_end(input int sel);
        set_pins(sel, 1'b0, 1'b0, 1'b0);
        #HALF;
        set_pins(sel, 1'b0, 1'b0, 1'b1);
        #GAP;
    endtask

    // Reference model: whole-frame effect of nbits clocked MSB first.
    task automatic model_frame(input int sel, input logic [31:0] bits, input int nbits,
                               output logic exp_stb, output logic [15:0] exp_rd);
        int a, d, fl, v, addr, data;
        a = aw(sel); d = dw(sel); fl = 1 + a + d;
        exp_stb = 1'b0;
        exp_rd  = '0;
        if (nbits != fl) begin
            if (mdl_ferr[sel] < 15) mdl_ferr[sel]++;
        end else begin
            v    = int'(bits);
            addr = (v >> d) % (1 << a);
            data = v % (1 << d);
            if (addr >= nr(sel))         mdl_aerr[sel] = 1;
            else if (((v >> (fl - 1)) & 1) == 1) begin
                mdl[sel][addr] = 16'(data);
                exp_stb = 1'b1;
            end else exp_rd = mdl[sel][addr];
        end
    endtask

    task automatic do_frame(input int sel, input logic [31:0] bits, input int nbits, input string tag);
        logic [31:0] cv, ov, exp_ov;
        logic c, o, exp_stb;
        logic [15:0] exp_rd, got_rd;
        int s0, fl, a;
        a  = aw(sel);
        fl = 1 + a + dw(sel);
        s0 = get_strb(sel);
        cv = '0; ov = '0; exp_ov = '0; got_rd = '0;
        set_pins(sel, 1'b0, 1'b0, 1'b0);
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            bit_cycle(sel, bits[nbits-1-i], c, o);
            cv[i] = c;
            ov[i] = o;
        end
        frame_end(sel);
        model_frame(sel, bits, nbits, exp_stb, exp_rd);
        check({tag, " regs"}, get_flat(sel), exp_flat(sel));
        check({tag, " addr_err"}, 192'(get_aerr(sel)), 192'(mdl_aerr[sel]));
        check({tag, " frame_err_cnt"}, 192'(get_ferr(sel)), 192'(mdl_ferr[sel]));
        check({tag, " strobe_cycles"}, 192'(get_strb(sel) - s0), exp_stb ? 192'd1 : 192'd0);
        if (exp_stb) check({tag, " wr_addr"}, 192'(get_waddr(sel)), 192'(int'(bits >> dw(sel)) % (1 << a)));
        if (nbits == fl && bits[fl-1] == 1'b0) begin
            for (int i = a + 1; i < fl; i++) begin
                got_rd    = {got_rd[14:0], cv[i]};
                exp_ov[i] = 1'b1;
            end
            check({tag, " read_data"}, 192'(got_rd), 192'(exp_rd));
            check({tag, " oe_window"}, 192'(ov), 192'(exp_ov));
        end
        check({tag, " idle_pins"}, 192'({get_cipo(sel), get_oe(sel)}), 192'd0);
    endtask

    task automatic pulse_clr(input int sel);
        if (sel == 0) err_clr_a = 1'b1; else err_clr_b = 1'b1;
        #10;
        err_clr_a = 1'b0; err_clr_b = 1'b0;
        #20;
        mdl_aerr[sel] = 0;
        mdl_ferr[sel] = 0;
    endtask

    initial begin
        logic [31:0] v, bits;
        logic c, o;
        int sel, a, d, fl, len, r, s0;

        for (int s = 0; s < 2; s++) begin
            mdl_aerr[s] = 0; mdl_ferr[s] = 0;
            for (int k = 0; k < 16; k++) mdl[s][k] = '0;
        end
        set_pins(0, 1'b0, 1'b0, 1'b1);
        set_pins(1, 1'b0, 1'b0, 1'b1);
        #28;
        for (int s = 0; s < 2; s++) begin
            check("reset regs", get_flat(s), 192'd0);
            check("reset outs", 192'({get_cipo(s), get_oe(s), get_aerr(s) != 0, get_ferr(s) != 0}), 192'd0);
            check("reset wr_addr", 192'(get_waddr(s)), 192'd0);
        end
        check("reset strobe", 192'({strobe_a, strobe_b}), 192'd0);
        rst_n = 1'b1;
        #100;

        // Write 0xA5 to reg 2.
        do_frame(0, 32'b1_0000010_10100101, 16, "wr_r2");
        check("wr_r2 byte", 192'(regs_a), 192'h00_00_A5_00_00);

        // Write 0x3C to reg 4, then read it back.
        do_frame(0, 32'b1_0000100_00111100, 16, "wr_r4");
        do_frame(0, 32'b0_0000100_11010010, 16, "rd_r4");
        check("rd_r4 regs", 192'(regs_a), 192'h3C_00_A5_00_00);

        // Out-of-range write, then clear.
        do_frame(0, 32'b1_0000101_11111111, 16, "wr_bad");
        check("wr_bad flag", 192'(aerr_a), 192'd1);
        pulse_clr(0);
        check("clr addr_err", 192'(aerr_a), 192'd0);

        // Short and long frames to reg 0.
        v = 32'b1_0000000_01110111;
        do_frame(0, v >> 1, 15, "short");
        do_frame(0, (v << 1) | 32'd1, 17, "long");
        check("len_err count", 192'(ferr_a), 192'd2);
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) do_frame(0, v >> 1, 15, "sat_s");
            else            do_frame(0, v << 1, 17, "sat_l");
        end
        check("len_err saturate", 192'(ferr_a), 192'd15);
        pulse_clr(0);
        check("clr frame_err", 192'(ferr_a), 192'd0);

        // Wide instance: write 0xBEEF to reg 11 and read it back.
        do_frame(1, {11'b0, 1'b1, 4'd11, 16'hBEEF}, 21, "b_wr11");
        check("b_wr11 slice", 192'(regs_b[191:176]), 192'hBEEF);
        do_frame(1, {11'b0, 1'b0, 4'd11, 16'h0000}, 21, "b_rd11");
        do_frame(1, {11'b0, 1'b0, 4'd13, 16'h1234}, 21, "b_rdbad");

        // Randomised mix of reads, writes, bad addresses and bad lengths.
        for (int k = 0; k < 30; k++) begin
            sel = int'($urandom_range(0, 1));
            a = aw(sel); d = dw(sel); fl = 1 + a + d;
            v = (32'($urandom_range(0, 1)) << (a + d))
              | (32'($urandom_range(0, nr(sel) + 1)) << d)
              | (32'($urandom) % (32'd1 << d));
            len = fl;
            r = int'($urandom_range(0, 7));
            if (r == 0)      len = fl - 1 - int'($urandom_range(0, 3));
            else if (r == 1) len = fl + 1 + int'($urandom_range(0, 1));
            if (len < fl) bits = v >> (fl - len);
            else          bits = (v << (len - fl)) | (32'($urandom) % (32'd1 << (len - fl)));
            do_frame(sel, bits, len, "rand");
        end

        // Reset in the middle of a write to reg 1; frame tail must be ignored.
        v  = 32'b1_0000001_01011010;
        s0 = strb_a;
        set_pins(0, 1'b0, 1'b0, 1'b0);
        #HALF;
        for (int i = 0; i < 10; i++) bit_cycle(0, v[15-i], c, o);
        rst_n = 1'b0;
        #30;
        check("midrst regs", 192'(regs_a), 192'd0);
        check("midrst errs", 192'({aerr_a, ferr_a}), 192'd0);
        for (int s = 0; s < 2; s++) begin
            mdl_aerr[s] = 0; mdl_ferr[s] = 0;
            for (int k = 0; k < 16; k++) mdl[s][k] = '0;
        end
        rst_n = 1'b1;
        #30;
        for (int i = 10; i < 16; i++) bit_cycle(0, v[15-i], c, o);
        frame_end(0);
        check("post_rst regs", 192'(regs_a), 192'd0);
        check("post_rst errs", 192'({aerr_a, ferr_a}), 192'd0);
        check("post_rst strobe", 192'(strb_a - s0), 192'd0);
        do_frame(0, v, 16, "after_rst");
        check("after_rst reg1", 192'(regs_a[15:8]), 192'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_regfile_periph.md
Name: spi_regfile_periph

Overview:
Parametrised SPI (mode 0) peripheral giving an external SPI controller read/write access to a bank of NUM_REGS configuration registers of DATA_W bits each. It is the generalised successor to the fixed 5 x 8-bit write-only register peripheral. It adds parametrised width and depth, register readback on CIPO, strict frame-length checking, address checking and error reporting. It sits between the chip's SPI pins and the output/PWM control logic, running entirely in the system clock domain with oversampled SPI inputs.

Parameters:
DATA_W, 8, register width and data-field length in bits
ADDR_W, 7, address-field length in bits
NUM_REGS, 5, number of implemented registers (1..2**ADDR_W)
SYNC_STAGES, 2, synchroniser depth on SCLK/COPI/nCS (>=2)
ERR_CNT_W, 4, width of saturating frame-error counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
SCLK  in  1  SPI clock, async to clk
COPI  in  1  SPI controller-out data
nCS  in  1  SPI chip select, active low
CIPO  out  1  SPI peripheral-out data
cipo_oe  out  1  output enable for CIPO pad
regs_flat  out  NUM_REGS*DATA_W  register contents; reg i at [i*DATA_W +: DATA_W]
wr_strobe  out  1  one-cycle pulse on committed write
wr_addr  out  ADDR_W  address of last committed write
addr_err  out  1  sticky: access to address >= NUM_REGS
frame_err_cnt  out  ERR_CNT_W  saturating count of malformed frames
err_clr  in  1  synchronous clear of addr_err and frame_err_cnt

Behaviour:
- Reset values: regs_flat=0, CIPO=0, cipo_oe=0, wr_strobe=0, wr_addr=0, addr_err=0, frame_err_cnt=0. Synchroniser chains reset to SCLK=0, COPI=0, nCS=1. FSM goes to IDLE.
- Inputs pass through SYNC_STAGES flops. Edges are detected against a further registered copy. All logic uses synchronised signals. Requires f_clk >= 4*f_SCLK.
- Frame layout, MSB first, sampled on SCLK rising: bit 0 = R/W (1 write, 0 read), then ADDR_W address bits, then DATA_W data bits. FRAME_LEN = 1+ADDR_W+DATA_W (16 by default).
- FSM states:
  - IDLE: wait for nCS falling -> CMD, bit_cnt=0.
  - CMD/ADDR: shift R/W and address bits. After the last address bit: write -> WDATA; read -> RDATA, snapshot selected register (or zeros if address >= NUM_REGS) into tx shift register.
  - WDATA: shift data bits.
  - RDATA: cipo_oe=1. CIPO presents tx MSB from the first SCLK falling edge after the last address bit, then shifts on each falling edge. COPI data bits are counted but ignored.
  - Any state: nCS rising -> END. END evaluates for one cycle, then -> IDLE.
- bit_cnt saturates at FRAME_LEN+1 to detect overlong frames.
- END handling:
  - bit_cnt == FRAME_LEN and write with addr < NUM_REGS: update the register, pulse wr_strobe, load wr_addr. This occurs on the clk cycle after synced nCS rising is detected.
  - Write with addr >= NUM_REGS: no update, no strobe, set addr_err.
  - Read with addr >= NUM_REGS: set addr_err.
  - bit_cnt != FRAME_LEN (short or long): discard frame, frame_err_cnt += 1, saturating at all-ones. addr_err is not updated.
- cipo_oe drops and CIPO returns to 0 on the cycle nCS rising is detected.
- SCLK edges while nCS is high are ignored.
- A frame begins only on an observed nCS falling edge. After reset release with nCS already low, the block stays IDLE until nCS goes high then low.
- nCS rising on the same cycle as an SCLK rising edge: the edge is not counted; nCS wins.
- err_clr on the same cycle as a new error: the error wins (the flag/counter reflects the new error on top of the cleared value).
- Async reset mid-frame: frame is dropped and all state is cleared immediately.
- Back-to-back frames separated by a single SCLK period of nCS high must both be handled.

Test Plan:
- Write frame 1_0000010_10100101 (reg 2 <= 0xA5) -> regs_flat[23:16]=0xA5, all other bits 0, wr_strobe high for exactly one cycle, wr_addr=2.
- Write 0x3C to reg 4, then read frame 0_0000100_xxxxxxxx -> CIPO bits 0,0,1,1,1,1,0,0 on falling edges 8..15, cipo_oe high only during the data phase, regs_flat unchanged.
- Write to address 5 (NUM_REGS=5) -> regs_flat unchanged, no wr_strobe, addr_err=1. Pulse err_clr -> addr_err=0.
- 15-bit frame, then 17-bit frame, both writing reg 0 -> reg 0 unchanged, frame_err_cnt=2. Repeat 20 times with ERR_CNT_W=4 -> frame_err_cnt saturates at 15.
- Assert rst_n low after bit 9 of a write, release with nCS still low, finish the frame -> no register write, no error. The next full frame is committed normally.
- Re-run the first and second scenarios with DATA_W=16, ADDR_W=4, NUM_REGS=12: write 0xBEEF to reg 11 -> regs_flat[191:176]=0xBEEF, and readback on CIPO = 0xBEEF.
